// File: rtl/ssaes_pkg.sv
// Shared definitions for the small-scale AES datapath: inverse S-box table,
// state-layout constants, FSM state enum and an ANF helper for masked lanes.
package ssaes_pkg;

    localparam int NIBBLES         = 16;
    localparam int RAND_PER_NIBBLE = 6;

    // Inverse of the forward small-scale AES S-box {6,B,5,4,2,E,7,A,9,D,F,C,3,1,0,8}
    localparam logic [3:0] INV_SBOX4 [16] = '{
        4'hE, 4'hD, 4'h4, 4'hC, 4'h3, 4'h2, 4'h0, 4'h6,
        4'hF, 4'h8, 4'h7, 4'h1, 4'hB, 4'h9, 4'h5, 4'hA
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Algebraic normal form of one output bit of INV_SBOX4. Bit m of the
    // result is the coefficient of the monomial prod(x_i for bit i set in m).
    function automatic logic [15:0] inv_sbox_anf(input int bitIdx);
        logic [15:0] t;
        logic [3:0]  lo;
        t = '0;
        for (int x = 0; x < 16; x++) begin
            t[x[3:0]] = INV_SBOX4[x[3:0]][bitIdx[1:0]];
        end
        for (int i = 0; i < 4; i++) begin
            for (int x = 0; x < 16; x++) begin
                if (((x >> i) & 1) != 0) begin
                    lo = x[3:0] ^ (4'd1 << i);
                    t[x[3:0]] = t[x[3:0]] ^ t[lo];
                end
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/dom_inv_sbox4.sv
// Two-share DOM lane computing the 4-bit inverse S-box with two register
// stages. The function is evaluated from its ANF: stage 1 forms all degree-2
// monomials, stage 2 forms the degree-3 and degree-4 ones, and the output
// XORs the monomials selected by the ANF coefficients within each domain.
module dom_inv_sbox4
    import ssaes_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [3:0]                 i_a,
    input  logic [3:0]                 i_b,
    input  logic [RAND_PER_NIBBLE-1:0] i_az,
    input  logic [RAND_PER_NIBBLE-1:0] i_bz,
    input  logic [RAND_PER_NIBBLE-1:0] i_z,
    output logic [3:0]                 o_a,
    output logic [3:0]                 o_b
);

    localparam logic [15:0] ANF0 = inv_sbox_anf(0);
    localparam logic [15:0] ANF1 = inv_sbox_anf(1);
    localparam logic [15:0] ANF2 = inv_sbox_anf(2);
    localparam logic [15:0] ANF3 = inv_sbox_anf(3);

    // Pair order p0..p5 = x0x1, x0x2, x0x3, x1x2, x1x3, x2x3
    logic [5:0] w_aI, w_aK, w_bI, w_bK;
    assign w_aI = {i_a[2], i_a[1], i_a[1], i_a[0], i_a[0], i_a[0]};
    assign w_aK = {i_a[3], i_a[3], i_a[2], i_a[3], i_a[2], i_a[1]};
    assign w_bI = {i_b[2], i_b[1], i_b[1], i_b[0], i_b[0], i_b[0]};
    assign w_bK = {i_b[3], i_b[3], i_b[2], i_b[3], i_b[2], i_b[1]};

    logic [3:0] r1_la, r1_lb;
    logic [5:0] r1_inA, r1_crA, r1_inB, r1_crB;
    logic [5:0] r1_rnd;

    // Stage 1: degree-2 DOM products, cross-domain terms refreshed by z
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_la  <= '0;
            r1_lb  <= '0;
            r1_inA <= '0;
            r1_crA <= '0;
            r1_inB <= '0;
            r1_crB <= '0;
            r1_rnd <= '0;
        end else begin
            r1_la  <= i_a;
            r1_lb  <= i_b;
            r1_inA <= w_aI & w_aK;
            r1_crA <= (w_aI & w_bK) ^ i_z;
            r1_inB <= w_bI & w_bK;
            r1_crB <= (w_bI & w_aK) ^ i_z;
            r1_rnd <= i_az ^ i_bz;
        end
    end

    logic [5:0] w_pA, w_pB;
    assign w_pA = r1_inA ^ r1_crA;
    assign w_pB = r1_inB ^ r1_crB;

    // Triple order t0..t3 = x0x1x2, x0x1x3, x0x2x3, x1x2x3
    logic [3:0] w_tPA, w_tLA, w_tPB, w_tLB;
    assign w_tPA = {w_pA[3], w_pA[1], w_pA[0], w_pA[0]};
    assign w_tPB = {w_pB[3], w_pB[1], w_pB[0], w_pB[0]};
    assign w_tLA = {r1_la[3], r1_la[3], r1_la[3], r1_la[2]};
    assign w_tLB = {r1_lb[3], r1_lb[3], r1_lb[3], r1_lb[2]};

    logic [3:0] r2_la, r2_lb;
    logic [5:0] r2_pA, r2_pB;
    logic [3:0] r2_tInA, r2_tCrA, r2_tInB, r2_tCrB;
    logic       r2_qInA, r2_qCrA, r2_qInB, r2_qCrB;
    logic       r2_fresh;

    // Stage 2: degree-3/4 DOM products; lower-degree monomials ride along
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_la    <= '0;
            r2_lb    <= '0;
            r2_pA    <= '0;
            r2_pB    <= '0;
            r2_tInA  <= '0;
            r2_tCrA  <= '0;
            r2_tInB  <= '0;
            r2_tCrB  <= '0;
            r2_qInA  <= 1'b0;
            r2_qCrA  <= 1'b0;
            r2_qInB  <= 1'b0;
            r2_qCrB  <= 1'b0;
            r2_fresh <= 1'b0;
        end else begin
            r2_la    <= r1_la;
            r2_lb    <= r1_lb;
            r2_pA    <= w_pA;
            r2_pB    <= w_pB;
            r2_tInA  <= w_tPA & w_tLA;
            r2_tCrA  <= (w_tPA & w_tLB) ^ r1_rnd[3:0];
            r2_tInB  <= w_tPB & w_tLB;
            r2_tCrB  <= (w_tPB & w_tLA) ^ r1_rnd[3:0];
            r2_qInA  <= w_pA[0] & w_pA[5];
            r2_qCrA  <= (w_pA[0] & w_pB[5]) ^ r1_rnd[4];
            r2_qInB  <= w_pB[0] & w_pB[5];
            r2_qCrB  <= (w_pB[0] & w_pA[5]) ^ r1_rnd[4];
            r2_fresh <= r1_rnd[5];
        end
    end

    logic [3:0]  w_tA, w_tB;
    logic [15:0] w_mA, w_mB;
    assign w_tA = r2_tInA ^ r2_tCrA;
    assign w_tB = r2_tInB ^ r2_tCrB;

    // Per-domain monomial vectors combined with the ANF; constant term in domain A only
    always_comb begin
        w_mA = '0;
        w_mB = '0;
        w_mA[0]  = 1'b1;
        w_mA[1]  = r2_la[0];  w_mB[1]  = r2_lb[0];
        w_mA[2]  = r2_la[1];  w_mB[2]  = r2_lb[1];
        w_mA[4]  = r2_la[2];  w_mB[4]  = r2_lb[2];
        w_mA[8]  = r2_la[3];  w_mB[8]  = r2_lb[3];
        w_mA[3]  = r2_pA[0];  w_mB[3]  = r2_pB[0];
        w_mA[5]  = r2_pA[1];  w_mB[5]  = r2_pB[1];
        w_mA[9]  = r2_pA[2];  w_mB[9]  = r2_pB[2];
        w_mA[6]  = r2_pA[3];  w_mB[6]  = r2_pB[3];
        w_mA[10] = r2_pA[4];  w_mB[10] = r2_pB[4];
        w_mA[12] = r2_pA[5];  w_mB[12] = r2_pB[5];
        w_mA[7]  = w_tA[0];   w_mB[7]  = w_tB[0];
        w_mA[11] = w_tA[1];   w_mB[11] = w_tB[1];
        w_mA[13] = w_tA[2];   w_mB[13] = w_tB[2];
        w_mA[14] = w_tA[3];   w_mB[14] = w_tB[3];
        w_mA[15] = r2_qInA ^ r2_qCrA;
        w_mB[15] = r2_qInB ^ r2_qCrB;
        o_a[0] = (^(w_mA & ANF0)) ^ r2_fresh;
        o_a[1] = (^(w_mA & ANF1)) ^ r2_fresh;
        o_a[2] = (^(w_mA & ANF2)) ^ r2_fresh;
        o_a[3] = (^(w_mA & ANF3)) ^ r2_fresh;
        o_b[0] = (^(w_mB & ANF0)) ^ r2_fresh;
        o_b[1] = (^(w_mB & ANF1)) ^ r2_fresh;
        o_b[2] = (^(w_mB & ANF2)) ^ r2_fresh;
        o_b[3] = (^(w_mB & ANF3)) ^ r2_fresh;
    end

endmodule

// File: rtl/inv_sub_text.sv
// Masked inverse substitution layer: streams the 16 nibbles of a 2-share
// state through one DOM inverse S-box lane and publishes both result shares
// at once when the last nibble leaves the lane.
module inv_sub_text
    import ssaes_pkg::*;
#(
    parameter int SBOX_LAT = 2
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [95:0] az,
    input  logic [95:0] bz,
    input  logic [95:0] z,
    output logic [63:0] aq,
    output logic [63:0] bq,
    output logic        busy,
    output logic        done
);

    state_e      r_state, w_next;
    logic [4:0]  r_cnt;
    logic [63:0] r_a, r_b, r_resA, r_resB;
    logic [95:0] r_az, r_bz, r_z;
    logic [3:0]  w_laneA, w_laneB;
    logic        w_accept, w_capture, w_lastFeed, w_lastDrain;

    assign w_lastFeed  = (r_cnt == 5'(NIBBLES - 1));
    assign w_lastDrain = (r_cnt == 5'(SBOX_LAT - 1));

    dom_inv_sbox4 u_lane (
        .clk   (clk),
        .rst_n (rst_n),
        .i_a   (r_a[3:0]),
        .i_b   (r_b[3:0]),
        .i_az  (r_az[5:0]),
        .i_bz  (r_bz[5:0]),
        .i_z   (r_z[5:0]),
        .o_a   (w_laneA),
        .o_b   (w_laneB)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next state; DONE also accepts start so back-to-back runs take 19 cycles
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_accept = start;
                w_next   = start ? ST_FEED : ST_IDLE;
            end
            ST_FEED: begin
                w_capture = (r_cnt >= 5'(SBOX_LAT));
                if (w_lastFeed) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_capture = 1'b1;
                if (w_lastDrain) w_next = ST_DONE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Nibble counter during FEED, reused as the drain counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   r_cnt <= '0;
        else if (w_accept)            r_cnt <= '0;
        else if (r_state == ST_FEED)  r_cnt <= w_lastFeed ? 5'd0 : r_cnt + 5'd1;
        else if (r_state == ST_DRAIN) r_cnt <= r_cnt + 5'd1;
    end

    // Input capture; shifting right presents nibble k at the lane in FEED cycle k
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a  <= '0;
            r_b  <= '0;
            r_az <= '0;
            r_bz <= '0;
            r_z  <= '0;
        end else if (w_accept) begin
            r_a  <= a;
            r_b  <= b;
            r_az <= az;
            r_bz <= bz;
            r_z  <= z;
        end else if (r_state == ST_FEED) begin
            r_a  <= r_a >> 4;
            r_b  <= r_b >> 4;
            r_az <= r_az >> RAND_PER_NIBBLE;
            r_bz <= r_bz >> RAND_PER_NIBBLE;
            r_z  <= r_z >> RAND_PER_NIBBLE;
        end
    end

    // Result shift registers: the nibble entered at the top ends at position k
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resA <= '0;
            r_resB <= '0;
        end else if (w_capture) begin
            r_resA <= {w_laneA, r_resA[63:4]};
            r_resB <= {w_laneB, r_resB[63:4]};
        end
    end

    // Output registers load the completed state together with the final capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aq <= '0;
            bq <= '0;
        end else if (r_state == ST_DRAIN && w_lastDrain) begin
            aq <= {w_laneA, r_resA[63:4]};
            bq <= {w_laneB, r_resB[63:4]};
        end
    end

    assign busy = (r_state == ST_FEED) || (r_state == ST_DRAIN);
    assign done = (r_state == ST_DONE);

endmodule
